// File: rtl/shifter_pkg.sv
// Shared types for the iterative shift unit: shift modes, FSM states and the
// default shift-amount width.
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2,
    SHIFT_ROR = 2'd3
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int XLEN_DEFAULT = 32;
  localparam int SHAMT_W      = $clog2(XLEN_DEFAULT);

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// Combinational single-step shifter: moves data by k bits (0..STEP) per mode.
// Mode 3 rotates right when SHIFTER_ROTATE_EN is defined, else passes data through.
module shift_step
  import shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int KW   = 6
) (
  input  logic [XLEN-1:0] data_i,
  input  shift_mode_t     mode_i,
  input  logic [KW-1:0]   k_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (mode_i)
      SHIFT_SLL: data_o = data_i << k_i;
      SHIFT_SRL: data_o = data_i >> k_i;
      // Sign bit of the running data register stays the latched operand MSB.
      SHIFT_SRA: data_o = $unsigned($signed(data_i) >>> k_i);
      SHIFT_ROR: begin
`ifdef SHIFTER_ROTATE_EN
        data_o = (data_i >> k_i) | (data_i << (XLEN - int'(k_i)));
`else
        data_o = data_i;
`endif
      end
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA unit shifting STEP bits per cycle under start/done.
// SHIFTER_ROTATE_EN selects ROR for mode 3 (otherwise mode 3 is a pass-through).
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [XLEN-1:0]          operand,
  input  logic [$clog2(XLEN)-1:0]  shamt,
  output logic                     busy,
  output logic                     done,
  output logic [XLEN-1:0]          result
);

  localparam int SW = $clog2(XLEN);
  localparam int KW = SW + 1;
  localparam logic [KW-1:0] STEP_K = KW'(STEP);

  state_t          state_q;
  shift_mode_t     mode_q;
  logic [XLEN-1:0] data_q;
  logic [SW-1:0]   rem_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic [KW-1:0]   rem_ext;
  logic [KW-1:0]   k;
  logic [SW-1:0]   rem_after;
  logic [XLEN-1:0] shifted;

  // k never exceeds the remaining count, so the narrowed subtraction is exact.
  always_comb begin
    rem_ext   = {1'b0, rem_q};
    k         = (rem_ext < STEP_K) ? rem_ext : STEP_K;
    rem_after = rem_q - k[SW-1:0];
  end

  shift_step #(
    .XLEN(XLEN),
    .KW  (KW)
  ) u_step (
    .data_i(data_q),
    .mode_i(mode_q),
    .k_i   (k),
    .data_o(shifted)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      mode_q   <= SHIFT_SLL;
      data_q   <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            data_q <= operand;
            mode_q <= shift_mode_t'(mode);
            rem_q  <= shamt;
            if (shamt == '0) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= operand;
            end else begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          data_q <= shifted;
          rem_q  <= rem_after;
          if (rem_after == '0) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= shifted;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Scoreboard bench for iterative_shifter: one STEP=1 and one STEP=4 instance.
// Mode 3 expectations follow SHIFTER_ROTATE_EN.
module tb_iterative_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r1_n, s1_start, b1, d1;
  logic [1:0]  s1_mode;
  logic [31:0] s1_op, res1;
  logic [4:0]  s1_sh;
  logic        r4_n, s4_start, b4, d4;
  logic [1:0]  s4_mode;
  logic [31:0] s4_op, res4;
  logic [4:0]  s4_sh;

  iterative_shifter #(.XLEN(32), .STEP(1)) dut1 (
    .clk(clk), .reset(r1_n), .start(s1_start), .mode(s1_mode), .operand(s1_op),
    .shamt(s1_sh), .busy(b1), .done(d1), .result(res1)
  );

  iterative_shifter #(.XLEN(32), .STEP(4)) dut4 (
    .clk(clk), .reset(r4_n), .start(s4_start), .mode(s4_mode), .operand(s4_op),
    .shamt(s4_sh), .busy(b4), .done(d4), .result(res4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];

  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] op, input int sh);
    case (m)
      2'd0: return op << sh;
      2'd1: return op >> sh;
      2'd2: return $unsigned($signed(op) >>> sh);
      default: begin
`ifdef SHIFTER_ROTATE_EN
        return (sh == 0) ? op : ((op >> sh) | (op << (32 - sh)));
`else
        return op;
`endif
      end
    endcase
  endfunction

  function automatic int exp_lat(input int sh, input int step);
    return (sh + step - 1) / step + 1;
  endfunction

  task automatic push_exp(input logic [1:0] m, input logic [31:0] op, input int sh, input int step);
    exp_res_q.push_back(model(m, op, sh));
    exp_lat_q.push_back(exp_lat(sh, step));
  endtask

  // Drives one request and waits (bounded) for done; returns observations only.
  task automatic do_op(input bit sel4, input logic [1:0] m, input logic [31:0] op,
                       input logic [4:0] sh, input bit hold, input bit b2b,
                       output logic [31:0] res, output int lat, output int bcnt, output bit tmo);
    if (!b2b) @(negedge clk);
    if (sel4) begin
      s4_start = 1'b1; s4_mode = m; s4_op = op; s4_sh = sh;
    end else begin
      s1_start = 1'b1; s1_mode = m; s1_op = op; s1_sh = sh;
    end
    @(posedge clk);
    lat = 0; bcnt = 0; tmo = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (hold) begin
        if (sel4) begin s4_op = '0; s4_sh = 5'd7; end
        else begin s1_op = '0; s1_sh = 5'd7; end
      end else begin
        if (sel4) s4_start = 1'b0; else s1_start = 1'b0;
      end
      if (sel4 ? b4 : b1) bcnt++;
      if (sel4 ? d4 : d1) break;
      if (lat >= 200) begin tmo = 1'b1; break; end
    end
    s1_start = 1'b0;
    s4_start = 1'b0;
    res = sel4 ? res4 : res1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({b1, d1, res1} !== 34'd0 || {b4, d4, res4} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_state: got b1=%0b d1=%0b r1=%h b4=%0b d4=%0b r4=%h, want all zero",
               b1, d1, res1, b4, d4, res4);
    end
    r1_n = 1'b1; r4_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({b1, d1, b4, d4} !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy/done %b, want 0000", {b1, d1, b4, d4});
    end
    $display("reset: released");
  endtask

  task automatic test_table(input string name, input bit sel4, input logic [1:0] m,
                            input logic [31:0] op, input logic [4:0] sh);
    logic [31:0] res, er;
    int lat, bcnt, el;
    bit tmo;
    push_exp(m, op, int'(sh), sel4 ? 4 : 1);
    do_op(sel4, m, op, sh, 1'b0, 1'b0, res, lat, bcnt, tmo);
    er = exp_res_q.pop_front();
    el = exp_lat_q.pop_front();
    n_checks++;
    if (tmo) begin
      n_fail++;
      $display("FAIL %s_timeout: no done within 200 cycles, want done at cycle %0d", name, el);
    end else if (res !== er || lat != el || bcnt != el - 1) begin
      n_fail++;
      $display("FAIL %s: got result=%h done_cycle=%0d busy=%0d, want result=%h done_cycle=%0d busy=%0d",
               name, res, lat, bcnt, er, el, el - 1);
    end
    $display("%s: mode=%0d op=%h sh=%0d -> %h @%0d", name, m, op, sh, res, lat);
  endtask

  task automatic test_srl_sra_sll();
    test_table("srl42_1", 1'b0, 2'd1, 32'd42, 5'd1);
    test_table("srl42_2", 1'b0, 2'd1, 32'd42, 5'd2);
    test_table("srl42_3", 1'b0, 2'd1, 32'd42, 5'd3);
    test_table("sra_neg4", 1'b0, 2'd2, 32'h8000_0000, 5'd4);
    test_table("sll1_31", 1'b0, 2'd0, 32'd1, 5'd31);
    test_table("sra_pos", 1'b0, 2'd2, 32'h4000_00F0, 5'd5);
  endtask

  task automatic test_step4();
    test_table("s4_srl7", 1'b1, 2'd1, 32'hFFFF_FFFF, 5'd7);
    test_table("s4_sra31", 1'b1, 2'd2, 32'h8123_4567, 5'd31);
    test_table("s4_sll8", 1'b1, 2'd0, 32'h0000_00AB, 5'd8);
    test_table("s4_zero", 1'b1, 2'd1, 32'h1234_5678, 5'd0);
  endtask

  task automatic test_mode3();
    test_table("m3_one", 1'b0, 2'd3, 32'h0000_0001, 5'd1);
    test_table("m3_s4", 1'b1, 2'd3, 32'hA5C3_0F01, 5'd13);
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, er;
    int lat, bcnt, el;
    bit tmo;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) push_exp(2'd1, 32'hDEAD_BEEF, 0, 1);
      else        push_exp(2'd1, 32'd42, 1, 1);
      if (i == 0) do_op(1'b0, 2'd1, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, res, lat, bcnt, tmo);
      else        do_op(1'b0, 2'd1, 32'd42, 5'd1, 1'b0, 1'b1, res, lat, bcnt, tmo);
      er = exp_res_q.pop_front();
      el = exp_lat_q.pop_front();
      n_checks++;
      if (tmo || res !== er || lat != el || bcnt != el - 1) begin
        n_fail++;
        $display("FAIL b2b_%0d: got result=%h done_cycle=%0d busy=%0d tmo=%0b, want result=%h done_cycle=%0d busy=%0d",
                 i, res, lat, bcnt, tmo, er, el, el - 1);
      end
      $display("b2b_%0d: -> %h @%0d", i, res, lat);
    end
  endtask

  task automatic test_start_held();
    logic [31:0] res, er;
    int lat, bcnt, el;
    bit tmo;
    push_exp(2'd1, 32'd42, 3, 1);
    do_op(1'b0, 2'd1, 32'd42, 5'd3, 1'b1, 1'b0, res, lat, bcnt, tmo);
    er = exp_res_q.pop_front();
    el = exp_lat_q.pop_front();
    n_checks++;
    if (tmo || res !== er || lat != el) begin
      n_fail++;
      $display("FAIL start_held: got result=%h done_cycle=%0d tmo=%0b, want result=%h done_cycle=%0d",
               res, lat, tmo, er, el);
    end
    $display("start_held: -> %h @%0d", res, lat);
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    @(negedge clk);
    s1_start = 1'b1; s1_mode = 2'd1; s1_op = 32'hFFFF_0000; s1_sh = 5'd20;
    @(negedge clk);
    s1_start = 1'b0;
    repeat (3) @(negedge clk);
    r1_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b1 !== 1'b0 || d1 !== 1'b0 || res1 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%0b done=%0b result=%h, want 0 0 00000000", b1, d1, res1);
    end
    r1_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (d1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_no_done: got done pulse after aborted op, want none");
    end
    $display("reset_mid: aborted op, done seen=%0b", saw_done);
    test_table("after_reset", 1'b0, 2'd0, 32'h0000_0003, 5'd2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      test_table("rand", i[0], 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
    end
  endtask

  initial begin
    r1_n = 1'b0; r4_n = 1'b0;
    s1_start = 1'b0; s1_mode = 2'd0; s1_op = '0; s1_sh = '0;
    s4_start = 1'b0; s4_mode = 2'd0; s4_op = '0; s4_sh = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_srl_sra_sll();
    test_step4();
    test_back_to_back();
    test_start_held();
    test_reset_mid();
    test_mode3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
